// File: rtl/mul16_pkg.sv
// mul16_pkg: shared types and constants for the shift-and-add multiply
// sequencer (mul16_seq_ctrl).
//   state_e   : controller states (WAIT is used only with a registered adder)
//   KPG_*     : kpg-encoded adder carry-in values
//   MUL_W     : default operand width
package mul16_pkg;

  localparam int MUL_W = 16;

  localparam logic [1:0] KPG_KILL = 2'b00;
  localparam logic [1:0] KPG_PROP = 2'b01;
  localparam logic [1:0] KPG_GEN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: unsigned W x W -> 2W multiply by iterative shift-and-add,
// sequencing an external kpg carry-lookahead adder (sum16bit).
//
// Ports
//   clk, rst_n      : clock (rising edge), async active-low reset
//   start           : request, sampled only while ready=1
//   in_a, in_b      : multiplicand / multiplier, captured with start
//   ready           : high in IDLE only
//   busy            : high while iterating (ITER/WAIT)
//   done            : one-cycle pulse, product valid
//   product         : result, held until the next accepted start
//   add_a, add_b    : adder operands (accumulator, multiplicand-or-zero)
//   add_kin         : adder carry-in, kpg encoded, always kill
//   add_sum         : adder result {carry, sum}
//
// Parameters
//   W       : operand width
//   ADD_LAT : adder latency, 0 (combinational) or 1 (registered)
//
// Build option
//   MUL16_EARLY_TERM_EN : when defined, a start with a zero operand skips the
//                         iterations and finishes with product 0.
module mul16_seq_ctrl
  import mul16_pkg::*;
#(
  parameter int W       = MUL_W,
  parameter int ADD_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic [1:0]     add_kin,
  input  logic [W:0]     add_sum
);

  localparam int             CW   = $clog2(W) + 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_e           r_state, w_nxt;
  logic [W-1:0]     r_acc, r_mq, r_mcand;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   r_product;
  logic             r_done;
  logic             w_step;
  logic             w_zero;

`ifdef MUL16_EARLY_TERM_EN
  assign w_zero = (in_a == '0) || (in_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  // One shift/add step per ITER cycle with a combinational adder; with a
  // registered adder ITER only presents operands and WAIT consumes the sum.
  assign w_step = ((r_state == ST_ITER) && (ADD_LAT == 0)) || (r_state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nxt = w_zero ? ST_DONE : ST_ITER;
      ST_ITER: begin
        if (ADD_LAT == 0) begin
          if (r_cnt == LAST) w_nxt = ST_DONE;
        end else begin
          w_nxt = ST_WAIT;
        end
      end
      ST_WAIT: w_nxt = (r_cnt == LAST) ? ST_DONE : ST_ITER;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mq      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_acc <= '0;
        r_cnt <= '0;
        // Zeroing both operand registers keeps the adder inputs at 0 and
        // makes {acc,mq} already equal the (zero) product.
        r_mcand <= w_zero ? '0 : in_a;
        r_mq    <= w_zero ? '0 : in_b;
      end else if (w_step) begin
        // {acc,mq} <= {add_sum,mq} >> 1 : the adder carry-out lands in acc MSB
        r_acc <= add_sum[W:1];
        r_mq  <= {add_sum[0], r_mq[W-1:1]};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == ST_DONE) begin
        r_product <= {r_acc, r_mq};
        r_done    <= 1'b1;
      end
    end
  end

  assign add_a   = r_acc;
  assign add_b   = r_mq[0] ? r_mcand : '0;
  assign add_kin = KPG_KILL;

  // done is registered out of DONE, so its pulse coincides with the IDLE
  // cycle in which the next start can already be accepted.
  assign ready   = (r_state == ST_IDLE);
  assign busy    = (r_state == ST_ITER) || (r_state == ST_WAIT);
  assign done    = r_done;
  assign product = r_product;

endmodule
